// File: rtl/word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// word_serializer_pkg
//
// Purpose : Shared definitions for the word serializer: datapath widths,
//           beat count, FSM state encodings and the beat-to-lane mapping.
//
// Contents:
//   BYTE_W, WORD_W, BEATS  datapath geometry (8-bit lanes of a 32-bit word)
//   BEAT_IDX_W, LAST_BEAT  beat index width and index of the last data beat
//   wser_state_e           IDLE=0, SEND=1, PARITY=2
//   lane_of_beat()         selects the byte lane that goes out on a beat
//
// The PARITY encoding is always declared; it is only reachable when the
// design is built with WSER_PARITY_EN defined.
// -----------------------------------------------------------------------------
package word_serializer_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;
  localparam int BEATS      = 4;
  localparam int BEAT_IDX_W = 2;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    PARITY = 2'd2
  } wser_state_e;

  // Lane 0 is the least significant byte. MSB-first streams walk the lanes
  // downwards from LAST_BEAT, LSB-first streams walk them upwards from 0.
  function automatic logic [BEAT_IDX_W-1:0] lane_of_beat(
    input logic [BEAT_IDX_W-1:0] beat,
    input bit                    msb_first
  );
    return msb_first ? (LAST_BEAT - beat) : beat;
  endfunction

endpackage

// File: rtl/word_serializer_splitter.sv
// -----------------------------------------------------------------------------
// word_serializer_splitter
//
// Purpose : Pure combinational 32-bit to 4 x 8-bit byte splitter. Lane 0 is
//           word_i[7:0], lane 3 is word_i[31:24]. Ordering for transmission
//           is decided by the controller, not here.
//
// Ports   :
//   word_i   in  WORD_W            word to split
//   lanes_o  out BEATS x BYTE_W    byte lanes, lanes_o[n] = word_i[8n+7:8n]
// -----------------------------------------------------------------------------
module word_serializer_splitter
  import word_serializer_pkg::*;
(
  input  logic [WORD_W-1:0]             word_i,
  output logic [BEATS-1:0][BYTE_W-1:0]  lanes_o
);

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    assign lanes_o[gi] = word_i[gi*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//
// Purpose : Accepts one 32-bit word over a valid/ready handshake, holds it and
//           emits its four byte lanes, one per handshake, on an 8-bit
//           valid/ready stream. Optionally appends a parity beat carrying the
//           XOR of the four bytes.
//
// Build option:
//   WSER_PARITY_EN  when defined, a fifth PARITY beat follows the four data
//                   beats and carries out_last; when undefined, out_last is on
//                   the fourth data beat and there is no PARITY state.
//
// Parameters:
//   MSB_FIRST  1: in_data[31:24] goes first; 0: in_data[7:0] goes first
//   CNT_W      width of the completed-word counter
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   reset      in   synchronous active-high reset
//   in_data    in   32-bit word from the producer
//   in_valid   in   producer has a word on in_data
//   in_ready   out  word is taken on this cycle (combinational from out_ready)
//   out_data   out  current byte
//   out_valid  out  out_data is valid
//   out_ready  in   consumer takes out_data on this cycle
//   out_last   out  current beat is the final beat of the word
//   busy       out  a word is held (SEND or PARITY)
//   word_cnt   out  number of fully sent words, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BYTE_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic [CNT_W-1:0]   word_cnt
);

  wser_state_e             state_q, state_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0]       out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;

  logic                    in_ready_w;
  logic                    accept;
  logic                    out_fire;

  // Lanes of the word that will be held after this edge, so the registered
  // out_data already shows the first byte in the cycle after acceptance.
  logic [BEATS-1:0][BYTE_W-1:0] lanes_d;

  word_serializer_splitter u_splitter (
    .word_i  (word_d),
    .lanes_o (lanes_d)
  );

`ifdef WSER_PARITY_EN
  logic [BYTE_W-1:0] parity_d;

  always_comb begin
    parity_d = '0;
    for (int i = 0; i < BEATS; i++) begin
      parity_d = parity_d ^ lanes_d[i];
    end
  end
`endif

  // out_last_q marks the final beat (beat 3, or the parity beat), so a new
  // word can be taken on the same edge that the final beat is consumed.
  assign in_ready_w = !reset && ((state_q == IDLE) || (out_last_q && out_ready));
  assign accept     = in_valid && in_ready_w;
  assign out_fire   = out_valid_q && out_ready;

  // Next-state and next-output logic. While stalled (no out_fire, no accept)
  // every _d equals its _q, which keeps the output beat stable.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;

    if (out_fire) begin
      if (state_q == SEND) begin
        beat_d = beat_q + 2'd1;
      end
      if (out_last_q) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
`ifdef WSER_PARITY_EN
      else if (state_q == SEND && beat_q == LAST_BEAT) begin
        state_d = PARITY;
      end
`endif
    end

    // Acceptance only happens in IDLE or on the final-beat handshake, so it
    // safely overrides the IDLE transition above.
    if (accept) begin
      word_d  = in_data;
      beat_d  = '0;
      state_d = SEND;
    end

    out_valid_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    out_last_d  = 1'b0;
    out_data_d  = out_data_q;   // IDLE keeps the last lane value

    case (state_d)
      SEND: begin
        out_data_d = lanes_d[lane_of_beat(beat_d, MSB_FIRST != 0)];
`ifndef WSER_PARITY_EN
        out_last_d = (beat_d == LAST_BEAT);
`endif
      end
`ifdef WSER_PARITY_EN
      PARITY: begin
        out_data_d = parity_d;
        out_last_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_w;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
//
// Two serializer instances share the clock: index 0 is MSB-first with an
// 8-bit counter, index 1 is LSB-first with a 2-bit counter. The expected byte
// stream of each accepted word is derived from shifts of the word value and
// kept in a queue; every cycle the outputs are compared against that queue.
// -----------------------------------------------------------------------------
module tb_word_serializer;

`ifdef WSER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int BEATS_TOT = PAR ? 5 : 4;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic             clk;
  logic [1:0]       rst;
  logic [1:0][31:0] in_data;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0][7:0]  out_data;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0]       out_last;
  logic [1:0]       busy;
  logic [7:0]       word_cnt_a;
  logic [1:0]       word_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt [2];
  beat_t exp_q [$];
  logic [31:0] stim_q [$];
  int first_fire;
  int last_fire;

  word_serializer #(.MSB_FIRST(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_last(out_last[0]), .busy(busy[0]),
    .word_cnt(word_cnt_a)
  );

  word_serializer #(.MSB_FIRST(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_last(out_last[1]), .busy(busy[1]),
    .word_cnt(word_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int msb_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int cnt_mod(input int d);
    return (d == 0) ? 256 : 4;
  endfunction

  function automatic int get_cnt(input int d);
    return (d == 0) ? int'(word_cnt_a) : int'(word_cnt_b);
  endfunction

  // k-th transmitted byte of a word
  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k, input int msb);
    int lane;
    logic [31:0] sh;
    lane = (msb != 0) ? 3 - k : k;
    sh   = w >> (8 * lane);
    return sh[7:0];
  endfunction

  task automatic push_word(input int d, input logic [31:0] w);
    beat_t b;
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 4; k++) begin
      b.data = exp_byte(w, k, msb_of(d));
      b.last = (k == 3) && !PAR;
      p      = p ^ b.data;
      exp_q.push_back(b);
    end
    if (PAR) begin
      b.data = p;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_reset(input int d);
    @(posedge clk); #1;
    rst[d] = 1'b1;
    in_valid[d] = 1'b0;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    model_cnt[d] = 0;
    exp_q.delete();
  endtask

  // Streams stim_q into instance d. mode 0: out_ready always high, in_valid
  // held; mode 1: random in_valid/out_ready; mode 2: out_ready dropped for
  // three cycles while beat 1 is presented.
  task automatic run_words(input int d, input int mode);
    int idx, n, guard, fires, stalls, cyc;
    logic prev_hold;
    logic [7:0] prev_data;
    logic prev_last;
    logic exp_ir;
    beat_t b;
    idx = 0; n = stim_q.size(); guard = 0; fires = 0; stalls = 0; cyc = 0;
    prev_hold = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    first_fire = -1; last_fire = -1;
    while ((idx < n || exp_q.size() != 0) && guard < 2000) begin
      @(posedge clk); #1;
      guard++; cyc++;
      if (prev_hold) begin
        n_checks++;
        if (out_valid[d] !== 1'b1 || out_data[d] !== prev_data || out_last[d] !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold dut%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   d, out_valid[d], out_data[d], out_last[d], prev_data, prev_last);
        end
      end
      in_valid[d] = (idx < n) && (mode != 1 || $urandom_range(0, 3) != 0);
      in_data[d]  = (idx < n) ? stim_q[idx] : $urandom();
      case (mode)
        1: out_ready[d] = 1'($urandom_range(0, 1));
        2: begin
          if (fires == 1 && stalls < 3) begin
            out_ready[d] = 1'b0;
            stalls++;
          end else begin
            out_ready[d] = 1'b1;
          end
        end
        default: out_ready[d] = 1'b1;
      endcase
      #1;
      n_checks++;
      if (get_cnt(d) != model_cnt[d] % cnt_mod(d)) begin
        n_fail++;
        $display("FAIL word_cnt dut%0d: got %0d expected %0d", d, get_cnt(d), model_cnt[d] % cnt_mod(d));
      end
      n_checks++;
      if (out_valid[d] !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL out_valid dut%0d: got %b expected %b", d, out_valid[d], exp_q.size() != 0);
      end
      exp_ir = (exp_q.size() == 0) || (exp_q[0].last && out_ready[d]);
      n_checks++;
      if (in_ready[d] !== exp_ir) begin
        n_fail++;
        $display("FAIL in_ready dut%0d: got %b expected %b", d, in_ready[d], exp_ir);
      end
      if (out_valid[d] && out_ready[d]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat dut%0d: got data %h expected no beat", d, out_data[d]);
        end else begin
          b = exp_q.pop_front();
          if (out_data[d] !== b.data || out_last[d] !== b.last) begin
            n_fail++;
            $display("FAIL beat dut%0d: got d=%h l=%b expected d=%h l=%b",
                     d, out_data[d], out_last[d], b.data, b.last);
          end
          if (b.last) model_cnt[d]++;
        end
        fires++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      if (in_valid[d] && in_ready[d]) begin
        push_word(d, stim_q[idx]);
        idx++;
      end
      prev_hold = out_valid[d] && !out_ready[d];
      prev_data = out_data[d];
      prev_last = out_last[d];
    end
    in_valid[d] = 1'b0;
    n_checks++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL timeout dut%0d: got %0d words sent expected %0d", d, idx, n);
      exp_q.delete();
    end
    $display("run dut%0d mode %0d: %0d words, %0d beats, %0d cycles", d, mode, n, fires, cyc);
  endtask

  task automatic test_reset();
    rst = 2'b11;
    in_valid = 2'b11;
    out_ready = 2'b11;
    in_data[0] = 32'h11223344;
    in_data[1] = 32'h55667788;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_in_ready dut%0d: got %b expected 0", d, in_ready[d]);
      end
      n_checks++;
      if (out_valid[d] !== 1'b0 || out_last[d] !== 1'b0 || busy[d] !== 1'b0 ||
          out_data[d] !== 8'h00 || get_cnt(d) != 0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got v=%b l=%b b=%b d=%h c=%0d expected all 0",
                 d, out_valid[d], out_last[d], busy[d], out_data[d], get_cnt(d));
      end
    end
    in_valid = 2'b00;
    rst = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (in_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL post_reset_in_ready dut%0d: got %b expected 1", d, in_ready[d]);
      end
    end
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    exp_q.delete();
    $display("reset: done");
  endtask

  task automatic test_msb_first();
    stim_q = '{32'hFFF0FF0F};
    run_words(0, 0);
    @(posedge clk); #1;
    n_checks++;
    if (word_cnt_a !== 8'd1) begin
      n_fail++;
      $display("FAIL msb_first_cnt: got %0d expected 1", word_cnt_a);
    end
  endtask

  task automatic test_lsb_first();
    stim_q = '{32'h12345678};
    run_words(1, 0);
  endtask

  task automatic test_backpressure();
    stim_q = '{32'hDEADBEEF, 32'h01020304};
    run_words(0, 2);
  endtask

  task automatic test_back_to_back();
    int cnt0;
    cnt0 = model_cnt[0];
    stim_q = '{32'hA1B2C3D4, 32'h00000000};
    run_words(0, 0);
    n_checks++;
    if (last_fire - first_fire + 1 != 2 * BEATS_TOT) begin
      n_fail++;
      $display("FAIL b2b_span: got %0d cycles expected %0d", last_fire - first_fire + 1, 2 * BEATS_TOT);
    end
    @(posedge clk); #1;
    n_checks++;
    if (get_cnt(0) != (cnt0 + 2) % 256) begin
      n_fail++;
      $display("FAIL b2b_cnt: got %0d expected %0d", get_cnt(0), (cnt0 + 2) % 256);
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      stim_q.delete();
      for (int i = 0; i < 20; i++) stim_q.push_back($urandom());
      run_words(d, 1);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w;
    w = 32'h5AC3E712;
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    in_data[0]  = w;
    out_ready[0] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_accept: got in_ready %b expected 1", in_ready[0]);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== exp_byte(w, 2, 1)) begin
      n_fail++;
      $display("FAIL midrst_beat2: got v=%b d=%h expected v=1 d=%h", out_valid[0], out_data[0], exp_byte(w, 2, 1));
    end
    rst[0] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_in_ready_rst: got %b expected 0", in_ready[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || word_cnt_a !== 8'd0) begin
      n_fail++;
      $display("FAIL midrst_abort: got v=%b b=%b c=%0d expected 0 0 0", out_valid[0], busy[0], word_cnt_a);
    end
    rst[0] = 1'b0;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_ready_rel: got %b expected 1", in_ready[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_resume: got out_valid %b expected 0", out_valid[0]);
    end
    model_cnt[0] = 0;
    exp_q.delete();
    $display("reset mid-word: done");
  endtask

  task automatic test_wrap();
    pulse_reset(1);
    stim_q = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005};
    run_words(1, 0);
    @(posedge clk); #1;
    n_checks++;
    if (word_cnt_b !== 2'd1) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %0d expected 1", word_cnt_b);
    end
  endtask

  initial begin
    rst       = 2'b11;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    in_data   = '0;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_word();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Sequencing controller for the 32-bit to 4×8-bit byte splitter datapath. Accepts one 32-bit word over a valid/ready handshake, holds it, and emits its four byte lanes one per handshake on an 8-bit valid/ready output stream. Sits between a word-wide producer (register file / memory read port) and a byte-wide consumer (UART-style sink, byte bus).

## Interface

Parameters:
- MSB_FIRST, default 1: 1 sends A[31:24] first and A[7:0] last; 0 reverses the order.
- CNT_W, default 8: width of the completed-word counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  32  word to serialize.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts in_data on this cycle.
- out_data  output  8  current byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data on this cycle.
- out_last  output  1  current beat is the final beat of the word.
- busy  output  1  a word is held; high in SEND and PARITY.
- word_cnt  output  CNT_W  number of fully sent words, modulo 2^CNT_W.

## Operation

- States: IDLE, SEND, PARITY. PARITY exists only with WSER_PARITY_EN.
- The input handshake fires when in_valid && in_ready. The held word register loads in_data, the 2-bit beat index resets to 0, and the state becomes SEND.
- In SEND, out_valid=1 and out_data = byte lane[beat]. Lane order follows MSB_FIRST.
- The output handshake fires when out_valid && out_ready. The beat index increments.
- Beat 3 in SEND is the final beat without parity. The PARITY beat is the final beat with parity.
- On the final-beat handshake, word_cnt increments, wrapping from all-ones to 0.
  - If in_valid is also high on that cycle, a new word is loaded and the state stays SEND at beat 0.
  - Otherwise the state goes to IDLE.
- in_ready = (state==IDLE) || (final beat && out_ready). This is combinational from out_ready, and it is forced to 0 while reset is high.
- out_data, out_valid and out_last are held stable while out_valid && !out_ready.
- in_valid is ignored while in_ready=0. A mid-word in_valid does not disturb the held word.
- In IDLE, out_valid=0 and out_last=0. out_data keeps the last lane value; it is don't-care for the consumer.

## Timing

- Reset values: state IDLE; held word, beat index, out_data, word_cnt all 0; out_valid=0, out_last=0, busy=0. in_ready is 0 during reset and 1 on the first cycle after reset.
- Latency: if the word is accepted at edge N, the first byte is valid during cycle N+1.
- Throughput with out_ready held high: 4 cycles per word without parity, 5 cycles per word with parity. There are no idle bubbles between back-to-back words.
- Reset mid-word: the word is aborted. out_valid=0 in the cycle after the reset edge, no remaining beats are emitted, and word_cnt is cleared.
- Simultaneous final-beat handshake and in_valid: the word count increments and the new word loads on the same edge.

## Configuration

- WSER_PARITY_EN defined: after the fourth data beat, a fifth PARITY beat sends the XOR of the four bytes. out_last moves from beat 3 to the parity beat.
- WSER_PARITY_EN undefined: there is no PARITY state, 4 beats per word, and out_last is on beat 3.

## Structure

- Shared include file wser_defs.vh holds:
  - state encodings (IDLE=2'd0, SEND=2'd1, PARITY=2'd2);
  - BYTE_W=8, WORD_W=32, BEATS=4.
- One sub-module: instantiate the existing splitter to produce the four byte lanes from the held word. The controller muxes lanes by beat index and MSB_FIRST.

## Test plan

- Reset release, MSB_FIRST=1, word 32'hFFF0FF0F, out_ready=1 → bytes FF, F0, FF, 0F on four consecutive cycles. out_last on the 0F beat; word_cnt=1. With WSER_PARITY_EN, a fifth beat FF carries out_last.
- MSB_FIRST=0, word 32'h12345678 → bytes 78, 56, 34, 12. Parity beat (macro on) is 08.
- Backpressure: drop out_ready for 3 cycles on beat 1 → out_data and out_valid hold, and no beat is skipped or duplicated.
- Back-to-back: in_valid held high with 32'hA1B2C3D4 then 32'h00000000, out_ready=1 → 8 contiguous beats (10 with parity), in_ready pulses only on final beats, word_cnt=2.
- Reset asserted during beat 2 → out_valid=0 the next cycle, word_cnt=0, in_ready=1 after release.
- word_cnt wrap, CNT_W=2: send 5 words → word_cnt reads 1.
